crubits_sync: RTL and testbench
===============================

Name: crubits_sync

Overview:
- Parametrised, clock-synchronous successor to the 4-bit CRU output latch for the TI-99/4A PEB interface.
- Holds NUM_BITS CRU-addressable output bits for one card at base >1x00, where x = cru_base.
- Synchronises the asynchronous TI CRU write strobe into the local clock domain, then commits writes on its deasserting edge.
- Provides CRU read-back and a one-cycle write-event port for downstream logic (e.g. TIPI control/handshake registers).

Parameters:
- NUM_BITS, 4, number of CRU bits held; power of 2, range 2..16.
- IDX_W, 2, bit-index width; must equal log2(NUM_BITS).
- SYNC_STAGES, 2, flops in the ti_cru_clk synchroniser; range 2..3.
- RESET_VAL, 0, NUM_BITS-wide reset value of bits.

Ports:
- clk  in  1  system clock; must be at least 4x the TI CRU strobe rate (>=12 MHz).
- reset  in  1  synchronous, active-high.
- cru_base  in  4  card select nibble; compared against addr[4:7].
- ti_cru_clk  in  1  TI CRUCLK, active low, asynchronous.
- ti_memen  in  1  TI MEMEN, active low; CRU cycles are valid only while it is high.
- addr  in  15  TI address A0..A14, indexed [0:14], A14 is the LSB.
- ti_cru_out  in  1  TI CRUOUT write data, asynchronous.
- ti_cru_in  out  1  read-back data.
- ti_cru_in_oe  out  1  read-back drive enable; the top level drives the bus only when this is 1.
- bits  out  NUM_BITS  bit register, indexed [0:NUM_BITS-1]; bits[0] is CRU bit 0.
- wr_valid  out  1  one-cycle pulse per committed write.
- wr_idx  out  IDX_W  index of the committed write.
- wr_val  out  1  data of the committed write.

Behaviour:
- Decode: sel = (addr[0:3]==4'b0001) && (addr[4:7]==cru_base) && ti_memen. idx = addr[15-IDX_W:14]. addr[8:14-IDX_W] are ignored, so bits mirror across the card's range.
- Reset: bits=RESET_VAL; every sync stage and the edge-delay flop=1 (strobe idle); hold register cleared with hold_sel=0; wr_valid=0, wr_idx=0, wr_val=0. Outputs take these values on the first clk edge with reset high.
- Sync: the ti_cru_clk chain has SYNC_STAGES flops; its last stage is s, and s_d is s delayed one cycle.
- Capture: every cycle in which s==0, hold_sel, hold_idx and hold_val are loaded from sel, idx and ti_cru_out.
- Commit: rise = s & ~s_d. In a cycle with rise==1 and hold_sel==1:
  - bits[hold_idx] <= hold_val;
  - wr_valid <= 1, wr_idx <= hold_idx, wr_val <= hold_val.
  - In every other cycle wr_valid <= 0; wr_idx and wr_val hold.
- Write latency: bits and wr_valid change SYNC_STAGES+1 clk edges after the first edge that samples ti_cru_clk high.
- Exactly one commit per strobe low-high cycle, regardless of how long the strobe stays low.
- Writing a value equal to the current bit still pulses wr_valid.
- Bus timing requirement on the TI side: addr and ti_cru_out are stable from the ti_cru_clk falling edge until SYNC_STAGES+1 clk after its rising edge.
- Strobe low for fewer than SYNC_STAGES clk may be lost; this is legal and causes no partial update.
- Non-selected strobe (wrong base, addr[0:3]!=0001, or ti_memen low): no change to bits, no wr_valid.
- Read-back is combinational from the asynchronous inputs with no clock involvement:
  - ti_cru_in_oe = sel;
  - ti_cru_in = sel ? bits[idx] : 0.
- Reset mid-operation: a strobe low at reset is discarded. A low-to-high transition already in flight at reset produces no commit, because the chain restarts at 1.
- Reset has priority over a same-cycle commit.
- Reset while the strobe is held low: the first rise after reset is ignored unless s has been sampled 0 since reset. A fresh low phase is required before a commit.

Test Plan:
- Reset then four selected writes (cru_base=0, addr >1000..>1003, cru_out=1, one strobe each) -> bits 1000, 1100, 1110, 1111 in turn. Each update arrives exactly 3 clk after the strobe rises (SYNC_STAGES=2). wr_valid pulses once per write, with wr_idx 0..3.
- cru_base=4'b0101, write addr >1500 with cru_out=1, then addr >1000 with cru_out=1 -> only the first write sets bits[0]. The second produces no wr_valid. Reading >1000 gives ti_cru_in_oe=0 and ti_cru_in=0.
- Bits=1111, write addr >1002 with cru_out=0; then read >1002 and >1003 -> bits=1101. Read-back gives ti_cru_in 0 then 1, with ti_cru_in_oe=1, and no clk is needed for the read-back.
- ti_memen=0 during a strobe to >1001 -> bits unchanged, wr_valid stays 0. Repeat the write to >1009 (mirror) with ti_memen=1 -> bits[1] set, wr_idx=1.
- Assert reset while ti_cru_clk is low, release reset, then raise ti_cru_clk -> no commit; bits=RESET_VAL. The next complete strobe commits normally.
- NUM_BITS=16, IDX_W=4: writes to >100F with 1, then >1000 with 1 -> bits[15]=1 and bits[0]=1, all others 0. wr_idx is 15 then 0.

Source files
------------

// File: rtl/crubits_sync.sv
// -----------------------------------------------------------------------------
// crubits_sync
//
// Clock-synchronous CRU output-bit latch for a TI-99/4A PEB card at CRU base
// >1x00 (x = cru_base). The asynchronous TI CRU write strobe is synchronised
// into clk. Address and data are captured while the synchronised strobe is low.
// The write is committed on the strobe's rising edge, which is detected in the
// clk domain. Read-back is purely combinational from the TI-side inputs.
//
// Ports:
//   clk          in   system clock (>= 4x the CRU strobe rate)
//   reset        in   synchronous, active-high reset
//   cru_base     in   card-select nibble, compared with addr[4:7]
//   ti_cru_clk   in   TI CRUCLK, active low, asynchronous
//   ti_memen     in   TI MEMEN, active low; CRU cycles are valid while it is high
//   addr         in   TI address A0..A14, indexed [0:14] (A14 is the LSB)
//   ti_cru_out   in   TI CRUOUT write data, asynchronous
//   ti_cru_in    out  read-back data (0 when not selected)
//   ti_cru_in_oe out  read-back drive enable
//   bits         out  bit register [0:NUM_BITS-1]; bits[0] is CRU bit 0
//   wr_valid     out  one-cycle pulse per committed write
//   wr_idx       out  index of the last committed write
//   wr_val       out  data of the last committed write
// -----------------------------------------------------------------------------
module crubits_sync #(
  parameter int                  NUM_BITS    = 4,
  parameter int                  IDX_W       = 2,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [0:NUM_BITS-1] RESET_VAL   = {NUM_BITS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          cru_base,
  input  logic                ti_cru_clk,
  input  logic                ti_memen,
  input  logic [0:14]         addr,
  input  logic                ti_cru_out,
  output logic                ti_cru_in,
  output logic                ti_cru_in_oe,
  output logic [0:NUM_BITS-1] bits,
  output logic                wr_valid,
  output logic [IDX_W-1:0]    wr_idx,
  output logic                wr_val
);

  logic                   w_sel;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_unused_addr;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_hold_sel;
  logic [IDX_W-1:0]       r_hold_idx;
  logic                   r_hold_val;
  logic [0:NUM_BITS-1]    r_bits;
  logic                   r_wr_valid;
  logic [IDX_W-1:0]       r_wr_idx;
  logic                   r_wr_val;

  // The low IDX_W address bits select the bit. The middle address bits are
  // deliberately ignored, so the bits mirror across the card's CRU range.
  assign w_idx = addr[15-IDX_W:14];

  // The ignored middle address bits are collected here only to mark them as intentionally unused.
  assign w_unused_addr = &{1'b0, addr[8:14-IDX_W]};

  // Card decode: CRU space >1xxx, matching base nibble, and MEMEN high.
  always_comb begin
    w_sel = 1'b0;
    if ((addr[0:3] == 4'b0001) && (addr[4:7] == cru_base) && ti_memen) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Combinational read-back, so a CRU read needs no clk edge.
  always_comb begin
    ti_cru_in_oe = w_sel;
    ti_cru_in    = 1'b0;
    if (w_sel) begin
      ti_cru_in = r_bits[w_idx];
    end else begin
      ti_cru_in = 1'b0;
    end
  end

  // Strobe synchroniser plus edge-delay flop. Both restart at 1 (idle), so a
  // rising edge already in flight at reset cannot be seen as a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b1}};
      r_s_d  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ti_cru_clk};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // Capture decode and data on every cycle while the synchronised strobe is
  // low. A rise then commits only if a low phase was seen since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_sel <= 1'b0;
      r_hold_idx <= {IDX_W{1'b0}};
      r_hold_val <= 1'b0;
    end else if (!w_s) begin
      r_hold_sel <= w_sel;
      r_hold_idx <= w_idx;
      r_hold_val <= ti_cru_out;
    end else begin
      r_hold_sel <= r_hold_sel;
      r_hold_idx <= r_hold_idx;
      r_hold_val <= r_hold_val;
    end
  end

  // Commit the captured write on the strobe's rising edge. wr_valid is a
  // one-cycle pulse. wr_idx and wr_val keep the last committed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bits     <= RESET_VAL;
      r_wr_valid <= 1'b0;
      r_wr_idx   <= {IDX_W{1'b0}};
      r_wr_val   <= 1'b0;
    end else if (w_rise && r_hold_sel) begin
      r_bits[r_hold_idx] <= r_hold_val;
      r_wr_valid         <= 1'b1;
      r_wr_idx           <= r_hold_idx;
      r_wr_val           <= r_hold_val;
    end else begin
      r_wr_valid <= 1'b0;
    end
  end

  assign bits     = r_bits;
  assign wr_valid = r_wr_valid;
  assign wr_idx   = r_wr_idx;
  assign wr_val   = r_wr_val;

endmodule

// File: tb/tb_crubits_sync.sv
// Directed testbench for crubits_sync. It uses one 4-bit instance with default
// parameters and one 16-bit instance. Both instances share the TI-side inputs.
// "Address >1xNN" is built as A0..A3=0001, A4..A7=x, and A8..A14 = NN (7 bits).
module tb_crubits_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cru_base = 4'd0;
  logic        ti_cru_clk = 1'b1;
  logic        ti_memen = 1'b1;
  logic [0:14] addr = 15'd0;
  logic        ti_cru_out = 1'b0;

  logic        rd4, oe4, wv4, wval4;
  logic [0:3]  bits4;
  logic [1:0]  widx4;
  logic        rd16, oe16, wv16, wval16;
  logic [0:15] bits16;
  logic [3:0]  widx16;

  int errors = 0;
  int checks = 0;

  // Monitor results from the last strobe.
  int          n4, first4, n16, first16;
  logic [0:3]  bits4_at2;

  crubits_sync u_dut4 (
    .clk(clk), .reset(reset), .cru_base(cru_base), .ti_cru_clk(ti_cru_clk),
    .ti_memen(ti_memen), .addr(addr), .ti_cru_out(ti_cru_out),
    .ti_cru_in(rd4), .ti_cru_in_oe(oe4), .bits(bits4),
    .wr_valid(wv4), .wr_idx(widx4), .wr_val(wval4)
  );

  crubits_sync #(.NUM_BITS(16), .IDX_W(4)) u_dut16 (
    .clk(clk), .reset(reset), .cru_base(cru_base), .ti_cru_clk(ti_cru_clk),
    .ti_memen(ti_memen), .addr(addr), .ti_cru_out(ti_cru_out),
    .ti_cru_in(rd16), .ti_cru_in_oe(oe16), .bits(bits16),
    .wr_valid(wv16), .wr_idx(widx16), .wr_val(wval16)
  );

  always #5 clk = ~clk;

  function automatic logic [0:14] mk(input logic [3:0] base, input int n);
    logic [6:0] lo;
    lo = 7'(n);
    return {4'b0001, base, lo};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one strobe (4 clk low), raise it at a negedge, then watch 6 posedges.
  // Edge k is counted from the raise, so edge 1 is the first to sample the strobe high.
  task automatic strobe(input logic [0:14] a, input logic d, input logic men);
    @(negedge clk);
    addr = a; ti_cru_out = d; ti_memen = men; ti_cru_clk = 1'b0;
    repeat (4) @(negedge clk);
    ti_cru_clk = 1'b1;
    n4 = 0; first4 = 0; n16 = 0; first16 = 0; bits4_at2 = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) bits4_at2 = bits4;
      if (wv4)  begin n4++;  if (first4 == 0)  first4 = k;  end
      if (wv16) begin n16++; if (first16 == 0) first16 = k; end
    end
    ti_memen = 1'b1;
  endtask

  task automatic test_reset();
    ti_cru_clk = 1'b1;
    do_reset();
    #1;
    checks++; if (bits4 !== 4'b0000) begin errors++; $display("FAIL reset_bits4: got %b want 0000", bits4); end
    checks++; if (bits16 !== 16'h0000) begin errors++; $display("FAIL reset_bits16: got %h want 0000", bits16); end
    checks++; if (wv4 !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wv4); end
    checks++; if (widx4 !== 2'd0) begin errors++; $display("FAIL reset_wr_idx: got %0d want 0", widx4); end
    checks++; if (wval4 !== 1'b0) begin errors++; $display("FAIL reset_wr_val: got %b want 0", wval4); end
  endtask

  task automatic test_sequential_writes();
    logic [0:3] exp_tab [4];
    logic [0:3] prev;
    exp_tab[0] = 4'b1000; exp_tab[1] = 4'b1100; exp_tab[2] = 4'b1110; exp_tab[3] = 4'b1111;
    cru_base = 4'd0;
    prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      strobe(mk(4'd0, i), 1'b1, 1'b1);
      checks++; if (n4 !== 1) begin errors++; $display("FAIL seq_pulses[%0d]: got %0d want 1", i, n4); end
      checks++; if (first4 !== 3) begin errors++; $display("FAIL seq_latency[%0d]: got edge %0d want 3", i, first4); end
      checks++; if (bits4_at2 !== prev) begin errors++; $display("FAIL seq_early[%0d]: got %b want %b", i, bits4_at2, prev); end
      checks++; if (bits4 !== exp_tab[i]) begin errors++; $display("FAIL seq_bits[%0d]: got %b want %b", i, bits4, exp_tab[i]); end
      checks++; if (widx4 !== 2'(i)) begin errors++; $display("FAIL seq_idx[%0d]: got %0d want %0d", i, widx4, i); end
      checks++; if (wval4 !== 1'b1) begin errors++; $display("FAIL seq_val[%0d]: got %b want 1", i, wval4); end
      prev = exp_tab[i];
    end
  endtask

  task automatic test_clear_readback();
    strobe(mk(4'd0, 2), 1'b0, 1'b1);
    checks++; if (n4 !== 1) begin errors++; $display("FAIL clr_pulses: got %0d want 1", n4); end
    checks++; if (bits4 !== 4'b1101) begin errors++; $display("FAIL clr_bits: got %b want 1101", bits4); end
    checks++; if (widx4 !== 2'd2) begin errors++; $display("FAIL clr_idx: got %0d want 2", widx4); end
    checks++; if (wval4 !== 1'b0) begin errors++; $display("FAIL clr_val: got %b want 0", wval4); end
    // Both reads happen within one clk half-period, so no edge is involved.
    @(posedge clk); #1;
    addr = mk(4'd0, 2); #1;
    checks++; if (rd4 !== 1'b0) begin errors++; $display("FAIL rd_1002: got %b want 0", rd4); end
    checks++; if (oe4 !== 1'b1) begin errors++; $display("FAIL oe_1002: got %b want 1", oe4); end
    addr = mk(4'd0, 3); #1;
    checks++; if (rd4 !== 1'b1) begin errors++; $display("FAIL rd_1003: got %b want 1", rd4); end
    checks++; if (oe4 !== 1'b1) begin errors++; $display("FAIL oe_1003: got %b want 1", oe4); end
  endtask

  task automatic test_memen_mirror();
    do_reset();
    strobe(mk(4'd0, 1), 1'b1, 1'b0);
    checks++; if (n4 !== 0) begin errors++; $display("FAIL memen_pulses: got %0d want 0", n4); end
    checks++; if (bits4 !== 4'b0000) begin errors++; $display("FAIL memen_bits: got %b want 0000", bits4); end
    ti_memen = 1'b0; #1;
    checks++; if (oe4 !== 1'b0) begin errors++; $display("FAIL memen_oe: got %b want 0", oe4); end
    ti_memen = 1'b1;
    strobe(mk(4'd0, 9), 1'b1, 1'b1);
    checks++; if (n4 !== 1) begin errors++; $display("FAIL mirror_pulses: got %0d want 1", n4); end
    checks++; if (bits4 !== 4'b0100) begin errors++; $display("FAIL mirror_bits: got %b want 0100", bits4); end
    checks++; if (widx4 !== 2'd1) begin errors++; $display("FAIL mirror_idx: got %0d want 1", widx4); end
  endtask

  task automatic test_equal_value();
    strobe(mk(4'd0, 1), 1'b1, 1'b1);
    checks++; if (n4 !== 1) begin errors++; $display("FAIL same_pulses: got %0d want 1", n4); end
    checks++; if (bits4 !== 4'b0100) begin errors++; $display("FAIL same_bits: got %b want 0100", bits4); end
  endtask

  task automatic test_base_select();
    do_reset();
    cru_base = 4'b0101;
    strobe(mk(4'b0101, 0), 1'b1, 1'b1);
    checks++; if (n4 !== 1) begin errors++; $display("FAIL base_hit_pulses: got %0d want 1", n4); end
    checks++; if (bits4 !== 4'b1000) begin errors++; $display("FAIL base_hit_bits: got %b want 1000", bits4); end
    strobe(mk(4'd0, 0), 1'b1, 1'b1);
    checks++; if (n4 !== 0) begin errors++; $display("FAIL base_miss_pulses: got %0d want 0", n4); end
    checks++; if (bits4 !== 4'b1000) begin errors++; $display("FAIL base_miss_bits: got %b want 1000", bits4); end
    addr = mk(4'd0, 0); #1;
    checks++; if (oe4 !== 1'b0) begin errors++; $display("FAIL base_miss_oe: got %b want 0", oe4); end
    checks++; if (rd4 !== 1'b0) begin errors++; $display("FAIL base_miss_rd: got %b want 0", rd4); end
    cru_base = 4'd0;
  endtask

  task automatic test_reset_low();
    int nv;
    do_reset();
    @(negedge clk);
    addr = mk(4'd0, 0); ti_cru_out = 1'b1; ti_memen = 1'b1; ti_cru_clk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; ti_cru_clk = 1'b1;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (wv4) nv++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL rstlow_pulses: got %0d want 0", nv); end
    checks++; if (bits4 !== 4'b0000) begin errors++; $display("FAIL rstlow_bits: got %b want 0000", bits4); end
    strobe(mk(4'd0, 0), 1'b1, 1'b1);
    checks++; if (n4 !== 1) begin errors++; $display("FAIL rstlow_next_pulses: got %0d want 1", n4); end
    checks++; if (bits4 !== 4'b1000) begin errors++; $display("FAIL rstlow_next_bits: got %b want 1000", bits4); end
  endtask

  task automatic test_wide();
    do_reset();
    strobe(mk(4'd0, 15), 1'b1, 1'b1);
    checks++; if (n16 !== 1) begin errors++; $display("FAIL wide_pulses15: got %0d want 1", n16); end
    checks++; if (first16 !== 3) begin errors++; $display("FAIL wide_latency: got edge %0d want 3", first16); end
    checks++; if (bits16 !== 16'h0001) begin errors++; $display("FAIL wide_bits15: got %b want 0000000000000001", bits16); end
    checks++; if (widx16 !== 4'd15) begin errors++; $display("FAIL wide_idx15: got %0d want 15", widx16); end
    strobe(mk(4'd0, 0), 1'b1, 1'b1);
    checks++; if (bits16 !== 16'h8001) begin errors++; $display("FAIL wide_bits0: got %b want 1000000000000001", bits16); end
    checks++; if (widx16 !== 4'd0) begin errors++; $display("FAIL wide_idx0: got %0d want 0", widx16); end
  endtask

  initial begin
    test_reset();
    test_sequential_writes();
    test_clear_readback();
    test_memen_mirror();
    test_equal_value();
    test_base_select();
    test_reset_low();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
